// File: rtl/ifu_pkg.sv
// Shared constants for the instruction fetch unit: memory map, enable levels,
// the fetch nop, and the PC legality check used by the next-PC selector.
package ifu_pkg;

    localparam logic [31:0] IM_START_ADDRESS     = 32'h0000_3000;
    localparam logic [31:0] IM_ISR_START_ADDRESS = 32'h0000_4180;
    localparam int          IM_SIZE              = 2048;
    localparam logic        IM_ENABLE            = 1'b1;
    localparam logic        IM_DISABLE           = 1'b0;
    localparam logic [31:0] IFU_NOP              = 32'h0000_0000;

    // Bounds are evaluated in 33 bits so a region ending at 2^32 cannot wrap.
    function automatic logic pc_is_legal(input logic [31:0] pc,
                                         input logic [31:0] start_pc,
                                         input int          words);
        logic [32:0] pc_end;
        pc_end = {1'b0, start_pc} + (33'(words) << 2);
        return (pc[1:0] == 2'b00) && (pc >= start_pc) && ({1'b0, pc} < pc_end);
    endfunction

endpackage

// File: rtl/ifu_npc_sel.sv
// Combinational next-PC selection and legality flag for the current PC.
module ifu_npc_sel
    import ifu_pkg::*;
#(
    parameter logic [31:0] START_PC = IM_START_ADDRESS,
    parameter logic [31:0] ISR_PC   = IM_ISR_START_ADDRESS,
    parameter int          IM_WORDS = IM_SIZE
) (
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] npc,
    output logic        pc_legal
);

    // Exception entry/return outrank a decode stall; a redirect under stall is dropped.
    always_comb begin
        npc = pc + 32'd4;
        if (reset)
            npc = START_PC;
        else if (exc_req)
            npc = ISR_PC;
        else if (eret_req)
            npc = epc;
        else if (stall)
            npc = pc;
        else if (redirect_valid)
            npc = redirect_pc;
    end

    assign pc_legal = pc_is_legal(pc, START_PC, IM_WORDS);

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, instruction memory port, IF/ID register
// and a debug count of valid fetches.
//
// state (pc, if_id_valid, if_id_fault) | meaning
// (START_PC, 0, 0)                     | just reset, first fetch presented
// (legal,    1, 0)                     | normal instruction latched
// (illegal,  1, 1)                     | nop latched, decode raises AdEL
// (any,      0, 0)                     | flushed by exception entry or eret
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] START_PC = IM_START_ADDRESS,
    parameter logic [31:0] ISR_PC   = IM_ISR_START_ADDRESS,
    parameter int          IM_WORDS = IM_SIZE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] im_addr,
    output logic        im_enable,
    input  logic [31:0] im_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic        if_id_fault,
    output logic [31:0] fetch_count
);

    logic [31:0] pc;
    logic [31:0] npc;
    logic        pc_legal;

    ifu_npc_sel #(
        .START_PC (START_PC),
        .ISR_PC   (ISR_PC),
        .IM_WORDS (IM_WORDS)
    ) u_npc_sel (
        .reset          (reset),
        .pc             (pc),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_req        (exc_req),
        .eret_req       (eret_req),
        .epc            (epc),
        .npc            (npc),
        .pc_legal       (pc_legal)
    );

    assign im_addr   = pc;
    assign im_enable = pc_legal ? IM_ENABLE : IM_DISABLE;

    always_ff @(posedge clk) begin
        pc <= npc;
        if (reset) begin
            if_id_instr <= IFU_NOP;
            if_id_pc    <= 32'd0;
            if_id_valid <= 1'b0;
            if_id_fault <= 1'b0;
            fetch_count <= 32'd0;
        end else if (exc_req || eret_req) begin
            if_id_instr <= IFU_NOP;
            if_id_pc    <= 32'd0;
            if_id_valid <= 1'b0;
            if_id_fault <= 1'b0;
        end else if (!stall) begin
            if_id_instr <= pc_legal ? im_rdata : IFU_NOP;
            if_id_pc    <= pc;
            if_id_valid <= 1'b1;
            if_id_fault <= !pc_legal;
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: free-run fetch, stall, redirect with delay slot,
// exception/eret flush, address faults and reset priority.
module tb_ifu;
    import ifu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] im_addr;
    logic        im_enable;
    logic [31:0] im_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic        if_id_fault;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [31:0] INSTR_A = 32'hAAAA_0001;
    localparam logic [31:0] INSTR_B = 32'hBBBB_0002;
    localparam logic [31:0] INSTR_C = 32'hCCCC_0003;

    always #5 clk = ~clk;

    ifu dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_req        (exc_req),
        .eret_req       (eret_req),
        .epc            (epc),
        .im_addr        (im_addr),
        .im_enable      (im_enable),
        .im_rdata       (im_rdata),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_valid    (if_id_valid),
        .if_id_fault    (if_id_fault),
        .fetch_count    (fetch_count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h3000: return INSTR_A;
            32'h3004: return INSTR_B;
            32'h3008: return INSTR_C;
            default:  return addr ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign im_rdata = mem_word(im_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " im_addr"},   im_addr, 32'h3000);
        check({tag, " im_enable"}, 32'(im_enable), 32'(IM_ENABLE));
        check({tag, " instr"},     if_id_instr, 32'h0);
        check({tag, " pc"},        if_id_pc, 32'h0);
        check({tag, " valid"},     32'(if_id_valid), 32'd0);
        check({tag, " fault"},     32'(if_id_fault), 32'd0);
        check({tag, " count"},     fetch_count, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic check_latch(input string tag, input logic [31:0] pc_exp,
                               input logic [31:0] instr_exp);
        check({tag, " pc"},    if_id_pc, pc_exp);
        check({tag, " instr"}, if_id_instr, instr_exp);
        check({tag, " valid"}, 32'(if_id_valid), 32'd1);
        check({tag, " fault"}, 32'(if_id_fault), 32'd0);
    endtask

    logic [31:0] fault_pcs [3];
    logic [31:0] cnt_before;

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        exc_req = 1'b0; eret_req = 1'b0; epc = 32'h0;
        step();
        step();
        check_reset_state("rst");
        reset = 1'b0;

        // Free run A, B, C
        step(); check_latch("run0", 32'h3000, INSTR_A);
        step(); check_latch("run1", 32'h3004, INSTR_B);
        step(); check_latch("run2", 32'h3008, INSTR_C);
        check("run count", fetch_count, 32'd3);
        check("run im_addr", im_addr, 32'h300C);

        // Stall two cycles at PC=0x3008
        do_reset();
        step(); step();
        check("pre-stall im_addr", im_addr, 32'h3008);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall im_addr", im_addr, 32'h3008);
            check_latch("stall hold", 32'h3004, INSTR_B);
            check("stall count", fetch_count, 32'd2);
        end
        stall = 1'b0;
        step();
        check_latch("stall release", 32'h3008, INSTR_C);
        check("release count", fetch_count, 32'd3);

        // Redirect with delay slot
        do_reset();
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h3100;
        step();
        redirect_valid = 1'b0;
        check_latch("delay slot", 32'h3004, INSTR_B);
        check("redirect im_addr", im_addr, 32'h3100);
        step();
        check_latch("redirect target", 32'h3100, 32'h5A5A_3100);

        // Exception with stall, then eret
        exc_req = 1'b1; stall = 1'b1;
        step();
        exc_req = 1'b0; stall = 1'b0;
        check("exc im_addr", im_addr, 32'h4180);
        check("exc flush valid", 32'(if_id_valid), 32'd0);
        check("exc flush pc", if_id_pc, 32'h0);
        check("exc flush instr", if_id_instr, 32'h0);
        step();
        check_latch("isr fetch", 32'h4180, 32'h5A5A_4180);
        eret_req = 1'b1; epc = 32'h3008;
        step();
        eret_req = 1'b0;
        check("eret im_addr", im_addr, 32'h3008);
        check("eret flush valid", 32'(if_id_valid), 32'd0);
        step();
        check_latch("eret target", 32'h3008, INSTR_C);

        // Address faults
        fault_pcs[0] = 32'h3002;
        fault_pcs[1] = 32'h2FFC;
        fault_pcs[2] = 32'h5000;
        for (int i = 0; i < 3; i++) begin
            redirect_valid = 1'b1; redirect_pc = fault_pcs[i];
            step();
            redirect_valid = 1'b0;
            check("fault im_addr", im_addr, fault_pcs[i]);
            check("fault im_enable", 32'(im_enable), 32'(IM_DISABLE));
            cnt_before = fetch_count;
            step();
            check("fault pc", if_id_pc, fault_pcs[i]);
            check("fault instr", if_id_instr, 32'h0);
            check("fault flag", 32'(if_id_fault), 32'd1);
            check("fault valid", 32'(if_id_valid), 32'd1);
            check("fault count", fetch_count, cnt_before + 32'd1);
        end

        // Last legal word is still fetched
        redirect_valid = 1'b1; redirect_pc = 32'h4FFC;
        step();
        redirect_valid = 1'b0;
        check("last word enable", 32'(im_enable), 32'(IM_ENABLE));
        step();
        check_latch("last word", 32'h4FFC, 32'h5A5A_4FFC);

        // Reset wins over redirect and stall
        redirect_valid = 1'b1; redirect_pc = 32'h3100; stall = 1'b1; reset = 1'b1;
        step();
        check_reset_state("rst prio");
        reset = 1'b0; redirect_valid = 1'b0; stall = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit: owns the program counter, drives the instruction memory's address/enable port, and captures the returned word into the IF/ID pipeline register. It sits between the instruction memory and the decode stage; the memory read is combinational, so a fetch completes in the same cycle the PC is presented. It handles stall, branch/jump redirect, exception entry to the ISR and `eret` return, and flags address faults instead of fetching.

## Interface

Parameters:
- `START_PC`, default `` `IM_START_ADDRESS `` (0x0000_3000): reset PC.
- `ISR_PC`, default `` `IM_ISR_START_ADDRESS `` (0x0000_4180): exception entry PC.
- `IM_WORDS`, default `` `IM_SIZE ``: number of 32-bit words in the instruction memory.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hold PC and IF/ID (hazard from decode).
- `redirect_valid` in 1: branch/jump taken; next PC is `redirect_pc`.
- `redirect_pc` in 32: branch/jump target.
- `exc_req` in 1: exception/interrupt accepted; fetch from `ISR_PC`, flush IF/ID.
- `eret_req` in 1: return from exception; fetch from `epc`, flush IF/ID.
- `epc` in 32: return address.
- `im_addr` out 32: byte address to the instruction memory (= PC).
- `im_enable` out 1: `` `IM_ENABLE `` when the PC is legal, otherwise `` `IM_DISABLE ``.
- `im_rdata` in 32: instruction word from the instruction memory.
- `if_id_instr` out 32: latched instruction.
- `if_id_pc` out 32: PC of the latched instruction.
- `if_id_valid` out 1: the IF/ID register holds a real instruction.
- `if_id_fault` out 1: the latched PC was illegal (AdEL on fetch).
- `fetch_count` out 32: number of instructions latched with valid=1 (debug).

## Operation

- Legal PC: `pc[1:0]==0` and `START_PC <= pc < START_PC + 4*IM_WORDS`. All comparisons are unsigned.
- Illegal PC: `im_enable` is deasserted and 0x0000_0000 (nop) is latched. `if_id_fault`=1 and `if_id_valid`=1, so decode raises AdEL.
- Next-PC priority, highest first:
  - `reset` → `START_PC`
  - `exc_req` → `ISR_PC`
  - `eret_req` → `epc`
  - `stall` → hold
  - `redirect_valid` → `redirect_pc`
  - otherwise `pc+4`
- `exc_req` and `eret_req` override `stall`.
- A redirect asserted together with `stall` is ignored. Decode re-asserts it when the stall releases.
- IF/ID update:
  - On `exc_req` or `eret_req`: valid=0, fault=0, instr=0, pc=0 (flush).
  - Else on `stall`: hold all fields.
  - Else: instr=`im_rdata` (or 0 if illegal), pc=PC, valid=1, fault=illegal.
- Delay slot: on `redirect_valid`, the word fetched in that same cycle (PC+4 of the branch) is latched normally. No flush.
- `pc+4` wraps modulo 2^32. A wrap produces an illegal PC and a fault; there is no special case.
- `fetch_count` increments by 1 on every edge where IF/ID is loaded with valid=1 (including faulting fetches). It wraps at 2^32.

## Timing

- Reset values: PC=`START_PC`, `if_id_instr`=0, `if_id_pc`=0, `if_id_valid`=0, `if_id_fault`=0, `fetch_count`=0.
- `im_addr` and `im_enable` are combinational from the PC register. Directly after reset, `im_addr`=0x3000 and `im_enable`=`IM_ENABLE`.
- Fetch latency: a word at PC appears on `if_id_instr` 1 cycle after the PC is presented.
- Redirect/exception penalty:
  - The target PC is presented the cycle after the request.
  - The target instruction reaches IF/ID 2 edges after the request.
- `reset` asserted mid-stall or mid-redirect wins in the same edge. All state returns to its reset values.
- No multi-cycle states. The "state machine" is PC plus the valid/fault flags; every transition is single-edge.

## Structure

- Shared header `im.h` already provides `IM_START_ADDRESS`, `IM_ISR_START_ADDRESS`, `IM_SIZE`, `IM_ENABLE`; add `IM_DISABLE` there.
- New header `ifu.h`: `IFU_NOP` (32'h0) and the PC legality bounds macro.
- One combinational sub-module `ifu_npc_sel`: computes the next PC from the priority list and produces the `pc_legal` flag.
- `ifu` itself holds the PC, IF/ID and counter registers.

## Test plan

- Reset then 3 free-running cycles with memory 0x3000→A, 0x3004→B, 0x3008→C:
  - `if_id_pc`=0x3000, 0x3004, 0x3008 with instr A, B, C; valid=1.
  - `fetch_count`=3.
- `stall` for 2 cycles at PC=0x3008:
  - `im_addr` holds 0x3008 and IF/ID holds 0x3004/B.
  - `fetch_count` is unchanged.
  - Release → next latch is 0x3008/C.
- `redirect_valid` with `redirect_pc`=0x3100 while PC=0x3004:
  - Latches 0x3004 (delay slot), then 0x3100; no flush.
- `exc_req` together with `stall`:
  - Next `im_addr`=0x4180; IF/ID valid=0 for one edge.
  - Then `if_id_pc`=0x4180.
  - Then `eret_req` with `epc`=0x3008 → flush, then `if_id_pc`=0x3008.
- Faults, each expecting `im_enable`=`IM_DISABLE`, `if_id_instr`=0, `if_id_fault`=1, valid=1:
  - Redirect to 0x3002.
  - Redirect to 0x2FFC.
  - Redirect to `START_PC + 4*IM_WORDS`.
- `reset` asserted while `redirect_valid` and `stall` are high:
  - All outputs return to reset values and PC=0x3000 on that edge.
